// File: rtl/alu_req_ctrl.sv
// -----------------------------------------------------------------------------
// alu_req_ctrl
//   Sequential front-end that owns the input ports of a combinational ALU.
//   It takes one operation at a time on a valid/ready request interface and
//   drives opcode and operands to the ALU. It then holds alu_enable for
//   EXEC_CYCLES cycles, captures the result and returns it on a valid/ready
//   response interface. An opcode above MAX_OP is never sent to the ALU. Instead
//   it produces an error response straight away.
//
// Ports
//   clk, rst                        clock (rising edge), async active-high reset
//   req_valid/req_ready             request handshake
//   req_op/req_src1/req_src2        request opcode and operands
//   alu_enable/alu_op/src1/src2     drive to the ALU
//   alu_out/alu_overflow            ALU result (combinational)
//   rsp_valid/rsp_ready             response handshake
//   rsp_data/rsp_overflow/rsp_err   captured result, overflow flag, illegal opcode
//   ovf_cnt                         saturating count of overflowing responses
//                                   (only with ALU_REQ_CTRL_OVF_CNT_EN defined)
//
// Configuration macro: ALU_REQ_CTRL_OVF_CNT_EN
//
// States
//   state  | meaning
//   IDLE   | ready for a request
//   EXEC   | ALU enabled, counting down to capture
//   RESP   | response held until the consumer accepts it
// -----------------------------------------------------------------------------
module alu_req_ctrl #(
  parameter int               DATA_W      = 32,
  parameter int               OP_W        = 5,
  parameter logic [OP_W-1:0]  MAX_OP      = OP_W'(17),
  parameter int               EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic              alu_enable,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_overflow,
  output logic              rsp_err
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W-1:0]   src2_q, src2_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  // Keeps req_ready low until the first clock edge after reset is released.
  logic                run_q;
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
  logic [7:0]          ovf_cnt_q, ovf_cnt_d;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
      ovf_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      run_q     <= 1'b1;
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
      ovf_cnt_q <= ovf_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_d   = req_op;
          src1_d = req_src1;
          src2_d = req_src2;
          if (req_op > MAX_OP) begin
            // Illegal opcode: the ALU is skipped and the error goes out directly.
            state_d = S_RESP;
            data_d  = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d = S_EXEC;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          data_d  = alu_out;
          ovf_d   = alu_overflow;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_REQ_CTRL_OVF_CNT_EN
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (state_q == S_RESP && rsp_ready && ovf_q && ovf_cnt_q != 8'hFF)
      ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    alu_enable = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      S_IDLE:  req_ready  = run_q;
      S_EXEC:  alu_enable = 1'b1;
      S_RESP:  rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  assign alu_op       = op_q;
  assign src1         = src1_q;
  assign src2         = src2_q;
  assign rsp_data     = data_q;
  assign rsp_overflow = ovf_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Testbench for alu_req_ctrl. There are two instances. u0 runs with
// EXEC_CYCLES=1 and u3 runs with EXEC_CYCLES=3. A selector routes the shared
// stimulus to one instance and picks which instance's outputs are observed.
module tb_alu_req_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [4:0]  req_op = '0;
  logic [31:0] req_src1 = '0, req_src2 = '0;

  int vectors = 0;
  int miscompares = 0;
  int ocnt[2];

  // Behavioural ALU: bit 32 is overflow.
  function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    v = 1'b0;
    case (op)
      5'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      default: r = (a << op[3:0]) ^ b;
    endcase
    return {v, r};
  endfunction

  logic rr0, en0, rv0, ov0, re0, aov0;
  logic [4:0] op0;
  logic [31:0] s1_0, s2_0, rd0, aout0;
  logic rr3, en3, rv3, ov3, re3, aov3;
  logic [4:0] op3;
  logic [31:0] s1_3, s2_3, rd3, aout3;
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
  logic [7:0] oc0, oc3;
`endif

  assign {aov0, aout0} = alu_f(op0, s1_0, s2_0);
  assign {aov3, aout3} = alu_f(op3, s1_3, s2_3);

  alu_req_ctrl #(.EXEC_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr0),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .alu_enable(en0), .alu_op(op0), .src1(s1_0), .src2(s2_0),
    .alu_out(aout0), .alu_overflow(aov0),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & ~sel),
    .rsp_data(rd0), .rsp_overflow(ov0), .rsp_err(re0)
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
    , .ovf_cnt(oc0)
`endif
  );

  alu_req_ctrl #(.EXEC_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr3),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .alu_enable(en3), .alu_op(op3), .src1(s1_3), .src2(s2_3),
    .alu_out(aout3), .alu_overflow(aov3),
    .rsp_valid(rv3), .rsp_ready(rsp_ready & sel),
    .rsp_data(rd3), .rsp_overflow(ov3), .rsp_err(re3)
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
    , .ovf_cnt(oc3)
`endif
  );

  logic m_rr, m_en, m_rv, m_ov, m_re;
  logic [4:0] m_op;
  logic [31:0] m_s1, m_s2, m_rd;
  logic [7:0] m_oc;
  always_comb begin
    m_rr = sel ? rr3 : rr0;
    m_en = sel ? en3 : en0;
    m_rv = sel ? rv3 : rv0;
    m_ov = sel ? ov3 : ov0;
    m_re = sel ? re3 : re0;
    m_op = sel ? op3 : op0;
    m_s1 = sel ? s1_3 : s1_0;
    m_s2 = sel ? s2_3 : s2_0;
    m_rd = sel ? rd3 : rd0;
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
    m_oc = sel ? oc3 : oc0;
`else
    m_oc = 8'd0;
`endif
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete transaction on the selected instance; caller sits #1 after a posedge.
  task automatic do_txn(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic [31:0] ed, input logic eo, input logic ee);
    int w, cyc, en_cnt, rdy_seen, exec, idx;
    exec = sel ? 3 : 1;
    idx  = sel ? 1 : 0;
    w = 0;
    while (!m_rr && w < 20) begin @(posedge clk); #1; w++; end
    chk({nm, " req_ready"}, m_rr, 1);
    req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; en_cnt = 0; rdy_seen = 0;
    while (!m_rv && cyc < 40) begin
      if (m_en) en_cnt++;
      if (m_rr) rdy_seen++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc, ee ? 1 : exec + 1);
    chk({nm, " enable cycles"}, en_cnt, ee ? 0 : exec);
    chk({nm, " busy ready"}, rdy_seen, 0);
    chk({nm, " rsp"}, {m_rv, m_rd, m_ov, m_re}, {1'b1, ed, eo, ee});
    chk({nm, " alu inputs held"}, {m_op, m_s1, m_s2}, {op, a, b});
    repeat (hold) begin
      @(posedge clk); #1;
      chk({nm, " hold"}, {m_rv, m_rr, m_en, m_ov, m_re, m_rd}, {1'b1, 1'b0, 1'b0, eo, ee, ed});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (eo && !ee && ocnt[idx] < 255) ocnt[idx]++;
    chk({nm, " after handshake"}, {m_rv, m_rr, m_en}, 3'b010);
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
    chk({nm, " ovf_cnt"}, m_oc, ocnt[idx]);
`endif
  endtask

  typedef struct {
    string       nm;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          hold;
    logic [31:0] d;
    logic        o, e;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] op;
    logic [31:0] a, b;
    logic [32:0] r;
    logic e;

    tbl[0] = '{"add_ovf", 5'd0,  32'hFF0F0F0F, 32'h80000000, 0, 32'h7F0F0F0F, 1'b1, 1'b0};
    tbl[1] = '{"sub",     5'd1,  32'h0F0F0F0F, 32'h50000000, 0, 32'hBF0F0F0F, 1'b0, 1'b0};
    tbl[2] = '{"and_bp",  5'd2,  32'h0F0F0F0F, 32'h000F000F, 5, 32'h000F000F, 1'b0, 1'b0};
    tbl[3] = '{"illegal", 5'd31, 32'h12345678, 32'h9ABCDEF0, 2, 32'h0,        1'b0, 1'b1};
    tbl[4] = '{"max_op",  5'd17, 32'h00000001, 32'h00000010, 0, 32'h00000012, 1'b0, 1'b0};
    tbl[5] = '{"op18",    5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0,        1'b0, 1'b1};
    ocnt[0] = 0; ocnt[1] = 0;

    #1;
    chk("reset outputs u0", {rr0, en0, rv0, op0, s1_0, s2_0, rd0, ov0, re0}, '0);
    chk("reset outputs u3", {rr3, en3, rv3, op3, s1_3, s2_3, rd3, ov3, re3}, '0);
    #21;
    rst = 1'b0;
    #1;
    chk("ready before first edge", {rr0, rr3}, 2'b00);
    @(posedge clk); #1;
    chk("ready after first edge", {rr0, rr3}, 2'b11);
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
    chk("ovf_cnt reset", {oc0, oc3}, 16'h0);
`endif

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 6; i++)
        do_txn(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].d, tbl[i].o, tbl[i].e);
    end

    // Random traffic against the behavioural model.
    for (int i = 0; i < 150; i++) begin
      sel = ($urandom_range(0, 1) == 1);
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      a = $urandom;
      b = $urandom;
      e = (op > 5'd17);
      r = e ? 33'd0 : alu_f(op, a, b);
      do_txn("rand", op, a, b, $urandom_range(0, 3), r[31:0], r[32], e);
    end

    // Reset during the second EXEC cycle of u3.
    sel = 1'b1;
    req_op = 5'd0; req_src1 = 32'h7FFFFFFF; req_src2 = 32'h1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid exec enable c1", m_en, 1);
    @(posedge clk); #1;
    chk("mid exec enable c2", m_en, 1);
    rst = 1'b1;
    #1;
    chk("rst outputs u3", {rr3, en3, rv3, op3, s1_3, s2_3, rd3, ov3, re3}, '0);
    chk("rst outputs u0", {rr0, en0, rv0, op0, s1_0, s2_0, rd0, ov0, re0}, '0);
    ocnt[0] = 0; ocnt[1] = 0;
`ifdef ALU_REQ_CTRL_OVF_CNT_EN
    chk("rst ovf_cnt", {oc0, oc3}, 16'h0);
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("ready low after rst", m_rr, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no rsp after rst", {m_rv, m_en, m_rr}, 3'b001);
    end
    do_txn("post_rst add", 5'd0, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1'b1, 1'b0);
    sel = 1'b0;
    do_txn("post_rst u0 sub", 5'd1, 32'h5, 32'h7, 0, 32'hFFFFFFFE, 1'b0, 1'b0);

`ifdef ALU_REQ_CTRL_OVF_CNT_EN
    for (int i = 0; i < 300; i++)
      do_txn("ovf_sat", 5'd0, 32'h80000000, 32'h80000000, 0, 32'h0, 1'b1, 1'b0);
    chk("ovf_cnt saturated", m_oc, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
